uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: the downstream consumer of the team's UART transmitter line. Samples the asynchronous `rx` line, detects start bits, recovers 8 data bits LSB-first at mid-bit, checks the stop bit and presents the byte through a valid/ack handshake. It also flags framing errors and overruns.

---
 rtl/uart_receiver.sv | 123 ++++++++++++
 tb/tb_uart_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: synchronizes rx, recovers 8N1 frames LSB-first at mid-bit,
// and hands bytes out through a valid/ack handshake with framing and overrun flags.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sh;
    logic             rx_p0;
    logic             rx_p1;
    logic             rx_s;

    // Stage p0/p1: two-flop synchronizer, idle-high out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;
    assign busy = (state != IDLE);

    // Framing FSM; later assignments in the STOP branch override the ack clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            idx   <= '0;
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_END) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end else begin
                                data       <= sh;
                                data_valid <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=16 with hand-computed expectations.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_chk;
    int n_pass;
    int cyc;
    int fall_cyc;
    int rise_cyc;
    int fe_cyc;
    int valid_cnt;
    int fe_hi;
    int busy_hi;
    logic watch_busy;
    logic dv_prev;
    logic [7:0] got_q[$];
    int lat;
    int v0;
    int f0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid && !dv_prev) begin
            valid_cnt <= valid_cnt + 1;
            rise_cyc  <= cyc;
            got_q.push_back(data);
        end
        if (frame_err) begin
            fe_hi  <= fe_hi + 1;
            fe_cyc <= cyc;
        end
        if (watch_busy && busy) busy_hi <= busy_hi + 1;
        dv_prev <= data_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; optionally pulses ack in the first cycle of the start bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_first);
        rx       = 1'b0;
        fall_cyc = cyc;
        if (ack_first) data_ack = 1'b1;
        cycles(1);
        data_ack = 1'b0;
        cycles(CPB - 1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop;
        cycles(CPB);
        rx = 1'b1;
    endtask

    task automatic ack;
        data_ack = 1'b1;
        cycles(1);
        data_ack = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; valid_cnt = 0; fe_hi = 0; busy_hi = 0;
        rise_cyc = 0; fe_cyc = 0; fall_cyc = 0;
        watch_busy = 1'b0; dv_prev = 1'b0;
        reset = 1'b0; rx = 1'b1; data_ack = 1'b0;
        cycles(3);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        watch_busy = 1'b1;
        cycles(1000);
        watch_busy = 1'b0;
        chk("idle_busy_cycles", busy_hi, 0);
        chk("idle_valid", valid_cnt, 0);

        // 0xA5 with latency check, then ack
        send_frame(8'hA5, 1'b1, 1'b0);
        lat = rise_cyc - fall_cyc;
        chk("a5_valid_cnt", valid_cnt, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_latency_in_window", (lat >= 9*CPB + CPB/2 + 2 && lat <= 9*CPB + CPB/2 + 4), 1'b1);
        chk("a5_ferr", fe_hi, 0);
        chk("a5_valid_before_ack", data_valid, 1'b1);
        ack();
        chk("a5_valid_after_ack", data_valid, 1'b0);

        // Back-to-back 0x00, 0xFF, 0x3C, each acked at the next start bit
        got_q.delete();
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        chk("b2b_valid_cnt", valid_cnt - v0, 3);
        chk("b2b_ovr", overrun, 1'b0);
        chk("b2b_byte0", (got_q.size() > 0) ? got_q[0] : 8'hEE, 8'h00);
        chk("b2b_byte1", (got_q.size() > 1) ? got_q[1] : 8'hEE, 8'hFF);
        chk("b2b_byte2", (got_q.size() > 2) ? got_q[2] : 8'hEE, 8'h3C);
        ack();

        // Overrun: 0x11 unacked, then 0x22 dropped
        send_frame(8'h11, 1'b1, 1'b0);
        chk("ovr_first_data", data, 8'h11);
        chk("ovr_first_flag", overrun, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_data_kept", data, 8'h11);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_valid_held", data_valid, 1'b1);
        ack();
        chk("ovr_cleared", overrun, 1'b0);
        chk("ovr_valid_cleared", data_valid, 1'b0);

        // Framing error, line held low three bit times, then a clean frame
        v0 = valid_cnt;
        f0 = fe_hi;
        send_frame(8'h5A, 1'b0, 1'b0);
        rx = 1'b0;
        cycles(3*CPB);
        rx = 1'b1;
        cycles(2*CPB);
        chk("fe_pulses", fe_hi - f0, 1);
        chk("fe_latency", fe_cyc - fall_cyc, 9*CPB + CPB/2 + 3);
        chk("fe_no_valid", valid_cnt - v0, 0);
        chk("fe_idle_after_break", busy, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("fe_recover_data", data, 8'h5A);
        chk("fe_recover_valid", valid_cnt - v0, 1);
        ack();

        // 4-cycle glitch on idle line
        v0 = valid_cnt;
        f0 = fe_hi;
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(3*CPB);
        chk("glitch_no_valid", valid_cnt - v0, 0);
        chk("glitch_no_ferr", fe_hi - f0, 0);
        chk("glitch_idle", busy, 1'b0);

        // Reset during bit 4 of a frame, then 0x81
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            cycles(CPB);
        end
        rx = 1'b0;
        cycles(CPB/2);
        chk("midrst_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", data_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ovr", overrun, 1'b0);
        cycles(3);
        reset = 1'b1;
        rx = 1'b1;
        cycles(2*CPB);
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        chk("midrst_next_data", data, 8'h81);
        chk("midrst_next_valid", valid_cnt - v0, 1);
        ack();
        cycles(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
